instruction_loader: RTL

//  Debug-side writer for the instruction memory. Assembles bytes from the debug UART

---
 rtl/instruction_loader_pkg.sv | 17 +
 rtl/instruction_loader_byte_assembler.sv | 42 ++++
 rtl/instruction_loader.sv | 109 ++++++++++
 3 files changed

// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the debug-side instruction loader: FSM encoding,
// word geometry and the default end-of-program marker.
package instruction_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_SETUP = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int WORD_BYTES = 4;

    localparam logic [31:0] HALT_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/instruction_loader_byte_assembler.sv
// Shifts UART bytes into a big-endian word (first byte ends up in the MSBs)
// and flags when a full word is pending.
module instruction_loader_byte_assembler
    import instruction_loader_pkg::*;
#(
    parameter int NBITS     = 8,
    parameter int INST_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NBITS-1:0]     data,
    input  logic                 valid,
    input  logic                 clear,
    input  logic                 enable,
    output logic [INST_BITS-1:0] word,
    output logic                 complete
);

    logic [2:0] cnt;
    logic       take;

    assign take     = enable && valid;
    assign complete = (cnt == 3'(WORD_BYTES));

    // A byte arriving on the same edge the pending word is handed off becomes
    // the first byte of the next word, so back-to-back traffic loses nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            word <= '0;
            cnt  <= '0;
        end else if (clear) begin
            cnt <= take ? 3'd1 : 3'd0;
            if (take) begin
                word <= {word[INST_BITS-NBITS-1:0], data};
            end
        end else if (take && !complete) begin
            word <= {word[INST_BITS-NBITS-1:0], data};
            cnt  <= cnt + 3'd1;
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// Debug-unit writer for instruction memory: turns UART bytes into 32-bit words
// and drives the memory debug write port with a clean one-cycle strobe per word.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int                   NBITS     = 8,
    parameter int                   INST_BITS = 32,
    parameter int                   CELLS     = 256,
    parameter logic [INST_BITS-1:0] HALT_INST = INST_BITS'(HALT_DEFAULT)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NBITS-1:0]     i_rx_data,
    input  logic                 i_rx_done,
    input  logic                 i_load_start,
    output logic [INST_BITS-1:0] o_dbg_addr,
    output logic [INST_BITS-1:0] o_dbg_inst,
    output logic                 o_dbg_wr_en,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam logic [INST_BITS-1:0] LAST_ADDR = INST_BITS'(CELLS - WORD_BYTES);
    localparam logic [INST_BITS-1:0] ADDR_STEP = INST_BITS'(WORD_BYTES);

    state_t               state;
    logic [INST_BITS-1:0] word;
    logic                 complete;
    logic                 enable;
    logic                 start_ok;
    logic                 last_write;
    logic                 transfer;
    logic                 clear;

    assign enable     = (state == ST_RECV) || (state == ST_SETUP) || (state == ST_WRITE);
    assign start_ok   = i_load_start && ((state == ST_IDLE) || (state == ST_DONE));
    assign last_write = (o_dbg_inst == HALT_INST) || (o_dbg_addr == LAST_ADDR);
    assign transfer   = complete &&
                        ((state == ST_RECV) || ((state == ST_WRITE) && !last_write));
    assign clear      = start_ok || transfer;

    instruction_loader_byte_assembler #(
        .NBITS     (NBITS),
        .INST_BITS (INST_BITS)
    ) u_assembler (
        .clk      (i_clk),
        .rst      (i_rst),
        .data     (i_rx_data),
        .valid    (i_rx_done),
        .clear    (clear),
        .enable   (enable),
        .word     (word),
        .complete (complete)
    );

    // The word is latched into o_dbg_inst on entry to SETUP so address and data
    // sit stable for a full cycle before the strobe rises in WRITE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            o_dbg_addr  <= '0;
            o_dbg_inst  <= '0;
            o_dbg_wr_en <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (i_load_start) begin
                        state      <= ST_RECV;
                        o_dbg_addr <= '0;
                        o_busy     <= 1'b1;
                        o_done     <= 1'b0;
                    end
                end
                ST_RECV: begin
                    if (complete) begin
                        state      <= ST_SETUP;
                        o_dbg_inst <= word;
                    end
                end
                ST_SETUP: begin
                    state       <= ST_WRITE;
                    o_dbg_wr_en <= 1'b1;
                end
                ST_WRITE: begin
                    o_dbg_wr_en <= 1'b0;
                    if (last_write) begin
                        state  <= ST_DONE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end else begin
                        o_dbg_addr <= o_dbg_addr + ADDR_STEP;
                        if (complete) begin
                            state      <= ST_SETUP;
                            o_dbg_inst <= word;
                        end else begin
                            state <= ST_RECV;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
